// File: rtl/seq_checker.sv
// Hardware checker for "trigger, then c, then d, then not e" on the datapath outputs.
// Verdicts are reported as one-cycle pulses plus saturating pass/fail counters.
module seq_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             clr_in,
  input  logic             a_in,
  input  logic             c_in,
  input  logic             d_in,
  input  logic             e_in,
  output logic             busy_ou,
  output logic             pass_ou,
  output logic             fail_ou,
  output logic [1:0]       fail_stage_ou,
  output logic [CNT_W-1:0] pass_cnt_ou,
  output logic [CNT_W-1:0] fail_cnt_ou,
  output logic             overrun_ou
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWaitC  = 2'd1;
  localparam logic [1:0] StWaitD  = 2'd2;
  localparam logic [1:0] StCheckE = 2'd3;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       stage_q, stage_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       verdict_stage;

  // Verdict and next-state decode; a low enable aborts silently.
  always_comb begin
    state_d       = state_q;
    pass_d        = 1'b0;
    fail_d        = 1'b0;
    verdict_stage = 2'd0;
    if (!en_in) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (a_in) state_d = StWaitC;
        end
        StWaitC: begin
          if (c_in) begin
            state_d = StWaitD;
          end else begin
            state_d       = StIdle;
            fail_d        = 1'b1;
            verdict_stage = 2'd1;
          end
        end
        StWaitD: begin
          if (d_in) begin
            state_d = StCheckE;
          end else begin
            state_d       = StIdle;
            fail_d        = 1'b1;
            verdict_stage = 2'd2;
          end
        end
        StCheckE: begin
          state_d = StIdle;
          if (!e_in) begin
            pass_d = 1'b1;
          end else begin
            fail_d        = 1'b1;
            verdict_stage = 2'd3;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Clear beats any coincident verdict or overrun, but never suppresses the pulses.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    stage_d    = stage_q;
    overrun_d  = overrun_q;
    if (clr_in) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      stage_d    = 2'd0;
      overrun_d  = 1'b0;
    end else begin
      if (pass_d) begin
        stage_d = 2'd0;
        if (pass_cnt_q != CntMax) pass_cnt_d = pass_cnt_q + 1'b1;
      end
      if (fail_d) begin
        stage_d = verdict_stage;
        if (fail_cnt_q != CntMax) fail_cnt_d = fail_cnt_q + 1'b1;
      end
      if (en_in && a_in && (state_q != StIdle)) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      stage_q    <= 2'd0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      stage_q    <= stage_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy_ou       = (state_q != StIdle);
  assign pass_ou       = pass_q;
  assign fail_ou       = fail_q;
  assign fail_stage_ou = stage_q;
  assign pass_cnt_ou   = pass_cnt_q;
  assign fail_cnt_ou   = fail_cnt_q;
  assign overrun_ou    = overrun_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: trigger-time reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_checker;

  localparam int CW = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_in = 1'b1;
  logic clr_in = 1'b0;
  logic a_in = 1'b0;
  logic c_in = 1'b0;
  logic d_in = 1'b0;
  logic e_in = 1'b0;
  logic          busy_ou, pass_ou, fail_ou, overrun_ou;
  logic [1:0]    fail_stage_ou;
  logic [CW-1:0] pass_cnt_ou, fail_cnt_ou;

  seq_checker #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_in         (en_in),
    .clr_in        (clr_in),
    .a_in          (a_in),
    .c_in          (c_in),
    .d_in          (d_in),
    .e_in          (e_in),
    .busy_ou       (busy_ou),
    .pass_ou       (pass_ou),
    .fail_ou       (fail_ou),
    .fail_stage_ou (fail_stage_ou),
    .pass_cnt_ou   (pass_cnt_ou),
    .fail_cnt_ou   (fail_cnt_ou),
    .overrun_ou    (overrun_ou)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a check is identified by the cycle its trigger was sampled;
  // the input that matters is chosen by how many edges have elapsed since then.
  int cyc = 0;
  int t0 = -1;
  int age;
  bit m_valid = 0;
  bit m_busy, m_pass, m_fail, m_ovr;
  int m_stage, m_pcnt, m_fcnt;
  bit v_pass, v_fail, v_ovr;
  int v_stage;

  always @(posedge clk) begin
    v_pass = 0; v_fail = 0; v_ovr = 0; v_stage = 0;
    age = (t0 < 0) ? 0 : cyc - t0;
    if (rst) begin
      t0 = -1; m_pass = 0; m_fail = 0; m_ovr = 0;
      m_stage = 0; m_pcnt = 0; m_fcnt = 0; m_valid = 1;
    end else begin
      if (!en_in) t0 = -1;
      else if (t0 < 0) begin
        if (a_in) t0 = cyc;
      end else begin
        v_ovr = a_in;
        if (age == 1 && !c_in) begin v_fail = 1; v_stage = 1; end
        else if (age == 2 && !d_in) begin v_fail = 1; v_stage = 2; end
        else if (age == 3) begin
          if (e_in) begin v_fail = 1; v_stage = 3; end
          else v_pass = 1;
        end
        if (v_pass || v_fail) t0 = -1;
      end
      m_pass = v_pass;
      m_fail = v_fail;
      if (clr_in) begin
        m_pcnt = 0; m_fcnt = 0; m_ovr = 0; m_stage = 0;
      end else begin
        if (v_pass) begin m_stage = 0; if (m_pcnt < CMAX) m_pcnt++; end
        if (v_fail) begin m_stage = v_stage; if (m_fcnt < CMAX) m_fcnt++; end
        if (v_ovr) m_ovr = 1;
      end
    end
    m_busy = (t0 >= 0);
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model busy",     int'(busy_ou),       int'(m_busy));
      check("model pass",     int'(pass_ou),       int'(m_pass));
      check("model fail",     int'(fail_ou),       int'(m_fail));
      check("model stage",    int'(fail_stage_ou), m_stage);
      check("model pass_cnt", int'(pass_cnt_ou),   m_pcnt);
      check("model fail_cnt", int'(fail_cnt_ou),   m_fcnt);
      check("model overrun",  int'(overrun_ou),    int'(m_ovr));
    end
  end

  // Apply inputs for the next rising edge, then step just past it.
  task automatic cyc_in(input logic a, input logic c, input logic d, input logic e);
    a_in = a; c_in = c; d_in = d; e_in = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pass();
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    cyc_in(0, 0, 1, 0);
    cyc_in(0, 0, 0, 0);
  endtask

  task automatic do_clr();
    clr_in = 1'b1;
    cyc_in(0, 0, 0, 0);
    clr_in = 1'b0;
  endtask

  initial begin
    // Reset values
    cyc_in(0, 0, 0, 0);
    check("rst busy", int'(busy_ou), 0);
    check("rst pass_cnt", int'(pass_cnt_ou), 0);
    check("rst overrun", int'(overrun_ou), 0);
    rst = 1'b0;
    cyc_in(0, 0, 0, 0);

    // Basic pass, pulse at T+4
    do_pass();
    check("pass pulse", int'(pass_ou), 1);
    check("pass cnt", int'(pass_cnt_ou), 1);
    check("pass stage", int'(fail_stage_ou), 0);
    do_clr();

    // Stage-1 fail at T+2
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 0, 0, 0);
    check("s1 fail pulse", int'(fail_ou), 1);
    check("s1 stage", int'(fail_stage_ou), 1);
    check("s1 fail_cnt", int'(fail_cnt_ou), 1);
    check("s1 busy", int'(busy_ou), 0);

    // Stage-2 fail at T+3
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    cyc_in(0, 0, 0, 0);
    check("s2 fail pulse", int'(fail_ou), 1);
    check("s2 stage", int'(fail_stage_ou), 2);

    // Stage-3 fail at T+4
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    cyc_in(0, 0, 1, 0);
    cyc_in(0, 0, 0, 1);
    check("s3 fail pulse", int'(fail_ou), 1);
    check("s3 stage", int'(fail_stage_ou), 3);
    check("s3 fail_cnt", int'(fail_cnt_ou), 3);

    // Trigger held high through the check: one pass, overrun, new check at T+4
    cyc_in(1, 0, 0, 0);
    cyc_in(1, 1, 0, 0);
    cyc_in(1, 0, 1, 0);
    cyc_in(1, 0, 0, 0);
    check("ovr pass pulse", int'(pass_ou), 1);
    check("ovr flag", int'(overrun_ou), 1);
    check("ovr pass_cnt", int'(pass_cnt_ou), 1);
    cyc_in(1, 0, 0, 0);
    check("ovr restart busy", int'(busy_ou), 1);
    cyc_in(0, 0, 0, 0);
    check("ovr restart fail", int'(fail_ou), 1);

    // Saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) do_pass();
    check("sat pass_cnt", int'(pass_cnt_ou), 3);
    do_clr();
    check("clr pass_cnt", int'(pass_cnt_ou), 0);
    check("clr overrun", int'(overrun_ou), 0);

    // Enable dropped at T+2
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    en_in = 1'b0;
    cyc_in(0, 0, 1, 0);
    check("en busy", int'(busy_ou), 0);
    check("en no fail", int'(fail_ou), 0);
    en_in = 1'b1;
    cyc_in(0, 0, 0, 0);
    check("en no pass", int'(pass_ou), 0);
    check("en pass_cnt", int'(pass_cnt_ou), 0);

    // Reset at T+2
    do_pass();
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    rst = 1'b1;
    cyc_in(0, 0, 1, 0);
    rst = 1'b0;
    check("midrst busy", int'(busy_ou), 0);
    check("midrst pass_cnt", int'(pass_cnt_ou), 0);
    cyc_in(0, 0, 0, 0);
    check("midrst no pulse", int'(pass_ou), 0);

    // Clear coincident with a stage-3 fail decision
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 0, 0, 0);
    check("pre-clr fail_cnt", int'(fail_cnt_ou), 1);
    cyc_in(1, 0, 0, 0);
    cyc_in(0, 1, 0, 0);
    cyc_in(0, 0, 1, 0);
    clr_in = 1'b1;
    cyc_in(0, 0, 0, 1);
    clr_in = 1'b0;
    check("clr+fail pulse", int'(fail_ou), 1);
    check("clr+fail cnt", int'(fail_cnt_ou), 0);
    check("clr+fail stage", int'(fail_stage_ou), 0);

    cyc_in(0, 0, 0, 0);
    cyc_in(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
